freq_meter: RTL and testbench

- Gated frequency counter downstream of the DDS key-scan stage. Consumes its clk_out (or clk_out_2) square wave and measures the rising-edge count over a fixed gate window of system clocks.
- Presents the last completed measurement as a binary word with a one-cycle valid strobe, for display or for closed-loop checking of the tuning word.
- With the default 1 s gate, the result reads directly in Hz.

---
 rtl/freq_meter.sv | 119 +++++++++++
 tb/tb_freq_meter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Brief    : Gated frequency counter; counts sig_in rising edges per gate.
// Revision : 1.0
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam logic [GATE_W-1:0] C_GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_sat;
  logic [CNT_W-1:0]   r_freq;
  logic               r_valid;
  logic               r_ovf;
  logic               r_busy;

  logic               w_rise;
  logic               w_at_max;
  logic               w_last;
  logic [CNT_W-1:0]   w_edge_inc;
  logic               w_sat_inc;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_at_max   = &r_edge_cnt;
  assign w_last     = (r_gate_cnt == C_GATE_LAST);
  assign w_edge_inc = (w_rise && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_sat_inc  = r_sat | (w_rise & w_at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (meas_en) w_state_nxt = S_GATE;
      S_GATE: begin
        if (!meas_en)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_LATCH;
      end
      S_LATCH: w_state_nxt = meas_en ? S_GATE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_s1    <= sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_busy  <= (w_state_nxt == S_GATE);
      r_valid <= 1'b0;
      if (r_state == S_GATE && meas_en) begin
        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        r_edge_cnt <= w_edge_inc;
        r_sat      <= w_sat_inc;
        // Result is loaded on the last gate cycle so it is visible together
        // with the strobe during the LATCH cycle.
        if (w_last) begin
          r_freq  <= w_edge_inc;
          r_ovf   <= w_sat_inc;
          r_valid <= 1'b1;
        end
      end else begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end
    end
  end

  assign freq_out   = r_freq;
  assign freq_valid = r_valid;
  assign overflow   = r_ovf;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Brief    : Self-checking bench for freq_meter against an edge-history model.
// Revision : 1.0
// ============================================================================
module tb_freq_meter;

  localparam int G  = 600;
  localparam int CW = 8;
  localparam int GW = 10;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          sig_in  = 1'b0;
  logic          meas_en = 1'b0;
  logic [CW-1:0] freq_out;
  logic          freq_valid;
  logic          overflow;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = -1;
  bit smp [0:99999];

  int mode = 0;
  int half = 1;
  int ph   = 0;
  bit lvl  = 1'b0;
  int last_freq = 0;
  int last_ovf  = 0;

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .GATE_W     (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .meas_en   (meas_en),
    .freq_out  (freq_out),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // History of sig_in as captured by the first synchronizer stage.
  always @(posedge clk) begin
    cyc = cyc + 1;
    smp[cyc] = rst_n ? sig_in : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    case (mode)
      0: sig_in = lvl;
      1: begin
        if (ph >= half - 1) begin
          sig_in = ~sig_in;
          ph = 0;
        end else begin
          ph++;
        end
      end
      default: sig_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A rise shows in cycle c when the sample two edges back was 0 and one back was 1.
  function automatic int model_count(input int first, input int len);
    int n = 0;
    for (int c = first; c < first + len; c++)
      if (smp[c-1] && !smp[c-2]) n++;
    return n;
  endfunction

  task automatic run_gates(input int n);
    int e, v, cnt;
    bit prev_busy;
    @(negedge clk);
    meas_en = 1'b1;
    e = cyc;
    for (int k = 0; k < n; k++) begin
      v = e + 1 + G + k * (G + 1);
      prev_busy = busy;
      @(negedge clk);
      while (!freq_valid && cyc < v + 5) begin
        prev_busy = busy;
        @(negedge clk);
      end
      check_val("valid_cycle", cyc, v);
      check_val("busy_in_gate", prev_busy, 1);
      check_val("busy_latch", busy, 0);
      cnt = model_count(v - G, G);
      last_freq = (cnt > 255) ? 255 : cnt;
      last_ovf  = (cnt > 255) ? 1 : 0;
      check_val("freq_out", freq_out, last_freq);
      check_val("overflow", overflow, last_ovf);
      if (k == n - 1) meas_en = 1'b0;
      @(negedge clk);
      check_val("valid_one_cycle", freq_valid, 0);
      check_val("busy_after_latch", busy, (k != n - 1) ? 1 : 0);
    end
  endtask

  task automatic quiet_check(input string tag, input int ncyc);
    int seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (freq_valid) seen++;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int e;
    repeat (3) @(negedge clk);
    check_val("rst_freq_out", freq_out, 0);
    check_val("rst_valid", freq_valid, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    mode = 1; half = 5;  run_gates(2);
    mode = 0; lvl = 1'b0; run_gates(1);
    lvl = 1'b1;           run_gates(1);
    for (int i = 0; i < 3; i++) begin
      mode = 1;
      half = $urandom_range(1, 9);
      run_gates(2);
    end
    mode = 2; run_gates(2);
    mode = 1; half = 10; run_gates(1);
    quiet_check("idle_no_valid", 20);
    half = 1; run_gates(1);

    // Abort mid-gate: result and overflow must survive, no strobe.
    half = 3;
    @(negedge clk);
    meas_en = 1'b1;
    e = cyc;
    while (cyc < e + 1 + 300) @(negedge clk);
    meas_en = 1'b0;
    @(negedge clk);
    check_val("abort_busy", busy, 0);
    quiet_check("abort_no_valid", G + 10);
    check_val("abort_keep_freq", freq_out, last_freq);
    check_val("abort_keep_ovf", overflow, last_ovf);
    run_gates(1);

    // Asynchronous reset in the middle of a gate.
    half = 1; run_gates(1);
    mode = 2;
    @(negedge clk);
    meas_en = 1'b1;
    repeat (200) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_freq_out", freq_out, 0);
    check_val("arst_overflow", overflow, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_valid", freq_valid, 0);
    meas_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_check("post_rst_no_valid", G + 5);
    check_val("post_rst_freq", freq_out, 0);
    mode = 1; half = 4; run_gates(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
